board_row_engine: RTL and testbench

//  Parametrised board-storage engine for Tetris Battle. Holds the H x W playfield, one W-bit row per address.

---
 rtl/tetris_pkg.sv | 35 +++
 rtl/board_row_file.sv | 51 +++++
 rtl/board_row_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_board_row_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris board storage engine: command codes,
// FSM state encoding, default board size and the attack-line lookup.
package tetris_pkg;

  localparam int W_DEF = 10;
  localparam int H_DEF = 20;

  localparam logic [1:0] OP_CHECK   = 2'd0;
  localparam logic [1:0] OP_LOCK    = 2'd1;
  localparam logic [1:0] OP_GARBAGE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_LOCK = 3'd2,
    ST_SCAN = 3'd3,
    ST_FILL = 3'd4,
    ST_GARB = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Attack lines sent to the opponent for a given number of cleared rows.
  function automatic logic [2:0] send_lut(input logic [2:0] cleared);
    logic [2:0] n;
    case (cleared)
      3'd2:    n = 3'd1;
      3'd3:    n = 3'd2;
      3'd0,
      3'd1:    n = 3'd0;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/board_row_file.sv
// H x W playfield storage: one row per address, one write port and two
// combinational read ports. Addresses carry one spare bit so callers can
// present indices past the floor; those read as 0 and are never written.
module board_row_file #(
  parameter int W  = 10,
  parameter int H  = 20,
  parameter int RW = $clog2(H)
) (
  input  logic          clk_40M,
  input  logic          rst,
  input  logic          we,
  input  logic [RW:0]   waddr,
  input  logic [W-1:0]  wdata,
  input  logic [RW:0]   raddr_e,
  output logic [W-1:0]  rdata_e,
  input  logic [RW:0]   raddr_d,
  output logic [W-1:0]  rdata_d,
  output logic [3:0]    top_nz
);

  localparam logic [RW:0] H_L = (RW+1)'(H);

  logic [W-1:0] rows_q [H];
  logic [W-1:0] rows_d [H];

  // Next array contents: at most one row replaced per cycle.
  always_comb begin
    rows_d = rows_q;
    if (we && (waddr < H_L)) rows_d[waddr[RW-1:0]] = wdata;
  end

  // Array registers with synchronous clear.
  always_ff @(posedge clk_40M) begin
    if (rst) begin
      for (int r = 0; r < H; r++) rows_q[r] <= '0;
    end else begin
      rows_q <= rows_d;
    end
  end

  // Read ports plus occupancy of the top four rows for game-over detection.
  always_comb begin
    rdata_e = '0;
    rdata_d = '0;
    top_nz  = '0;
    if (raddr_e < H_L) rdata_e = rows_q[raddr_e[RW-1:0]];
    if (raddr_d < H_L) rdata_d = rows_q[raddr_d[RW-1:0]];
    for (int i = 0; i < 4; i++) top_nz[i] = |rows_q[i];
  end

endmodule

// File: rtl/board_row_engine.sv
// Board storage engine: collision check, piece lock with line clear and
// compaction, garbage insertion, and a registered display read port.
// One board row is touched per cycle in every phase.
module board_row_engine
  import tetris_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int H  = H_DEF,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic           clk_40M,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [RW-1:0]  cmd_row,
  input  logic [4*W-1:0] cmd_mask,
  input  logic [2:0]     cmd_n,
  input  logic [CW-1:0]  cmd_hole,
  output logic           rsp_valid,
  output logic           rsp_collide,
  output logic [2:0]     rsp_cleared,
  output logic           send_valid,
  output logic [2:0]     send_n,
  output logic           top_out,
  output logic [15:0]    total_lines,
  input  logic [RW-1:0]  disp_row,
  output logic [W-1:0]   disp_data
);

  localparam int          RW1  = RW + 1;
  localparam logic [RW:0] H_L  = RW1'(H);
  localparam logic [RW:0] LAST = RW1'(H - 1);

  state_e         state_q, state_d;
  logic [RW:0]    base_q, base_d;
  logic [1:0]     i_q, i_d;
  logic [RW:0]    rd_q, rd_d;
  logic [RW:0]    wr_q, wr_d;
  logic [RW:0]    cnt_q, cnt_d;
  logic           collide_q, collide_d;
  logic [4*W-1:0] mask_q, mask_d;
  logic [2:0]     n_q, n_d;
  logic [CW-1:0]  hole_q, hole_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_collide_q, rsp_collide_d;
  logic [2:0]     rsp_cleared_q, rsp_cleared_d;
  logic           send_valid_q, send_valid_d;
  logic [2:0]     send_n_q, send_n_d;
  logic           top_out_q, top_out_d;
  logic [15:0]    total_q, total_d;
  logic [W-1:0]   disp_data_q;

  logic           we;
  logic [RW:0]    waddr, raddr_e;
  logic [W-1:0]   wdata, rdata_e, rdata_d;
  logic [3:0]     top_nz;

  logic [RW:0]    cur_r;
  logic [W-1:0]   mask_i, garb_row;
  logic [2:0]     n_eff;
  logic [3:0]     nmask;
  logic [16:0]    total_sum;

  board_row_file #(.W(W), .H(H), .RW(RW)) u_rows (
    .clk_40M (clk_40M),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_e (raddr_e),
    .rdata_e (rdata_e),
    .raddr_d ({1'b0, disp_row}),
    .rdata_d (rdata_d),
    .top_nz  (top_nz)
  );

  // Operand helpers: current mask row, garbage row pattern, clamped line count.
  always_comb begin
    cur_r    = base_q + RW1'(i_q);
    mask_i   = mask_q[W*i_q +: W];
    garb_row = '1;
    if (int'(hole_q) < W) garb_row[hole_q] = 1'b0;
    n_eff    = (cmd_n > 3'd4) ? 3'd4 : cmd_n;
    for (int k = 0; k < 4; k++) nmask[k] = (3'(k) < n_eff);
  end

  // Command sequencing and row datapath.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    i_d           = i_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    collide_d     = collide_q;
    mask_d        = mask_q;
    n_d           = n_q;
    hole_d        = hole_q;
    rsp_valid_d   = 1'b0;
    rsp_collide_d = rsp_collide_q;
    rsp_cleared_d = rsp_cleared_q;
    send_valid_d  = 1'b0;
    send_n_d      = send_n_q;
    top_out_d     = top_out_q;
    total_d       = total_q;
    total_sum     = '0;
    we            = 1'b0;
    waddr         = rd_q;
    wdata         = '0;
    raddr_e       = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          base_d    = {1'b0, cmd_row};
          mask_d    = cmd_mask;
          n_d       = n_eff;
          hole_d    = cmd_hole;
          i_d       = '0;
          rd_d      = '0;
          cnt_d     = '0;
          collide_d = 1'b0;
          case (cmd_op)
            OP_LOCK:    state_d = ST_LOCK;
            OP_GARBAGE: begin
              state_d = ST_GARB;
              if (|(top_nz & nmask)) top_out_d = 1'b1;
            end
            default:    state_d = ST_CHK;
          endcase
        end
      end
      ST_CHK: begin
        raddr_e = cur_r;
        if (cur_r >= H_L) collide_d = collide_q | (|mask_i);
        else              collide_d = collide_q | (|(mask_i & rdata_e));
        i_d = i_q + 2'd1;
        if (i_q == 2'd3) state_d = ST_DONE;
      end
      ST_LOCK: begin
        raddr_e = cur_r;
        if (cur_r < H_L) begin
          we    = 1'b1;
          waddr = cur_r;
          wdata = rdata_e | mask_i;
        end
        i_d = i_q + 2'd1;
        if (i_q == 2'd3) begin
          state_d = ST_SCAN;
          rd_d    = LAST;
          wr_d    = LAST;
        end
      end
      ST_SCAN: begin
        // Full rows are dropped by holding wr; survivors slide down to wr.
        raddr_e = rd_q;
        if (&rdata_e) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          if (wr_q != rd_q) begin
            we    = 1'b1;
            waddr = wr_q;
            wdata = rdata_e;
          end
          wr_d = wr_q - 1'b1;
        end
        if (rd_q == '0) state_d = (cnt_d == '0) ? ST_DONE : ST_FILL;
        else            rd_d = rd_q - 1'b1;
      end
      ST_FILL: begin
        we    = 1'b1;
        waddr = wr_q;
        wdata = '0;
        wr_d  = wr_q - 1'b1;
        if (wr_q == '0) state_d = ST_DONE;
      end
      ST_GARB: begin
        // Ascending r so row r+n is still unmodified when it is copied.
        we    = 1'b1;
        waddr = rd_q;
        if (rd_q < H_L - RW1'(n_q)) begin
          raddr_e = rd_q + RW1'(n_q);
          wdata   = rdata_e;
        end else begin
          wdata = garb_row;
        end
        rd_d = rd_q + 1'b1;
        if (rd_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      rsp_valid_d   = 1'b1;
      rsp_collide_d = collide_d;
      rsp_cleared_d = (cnt_d > RW1'(7)) ? 3'd7 : cnt_d[2:0];
      send_n_d      = send_lut(rsp_cleared_d);
      send_valid_d  = (send_n_d != 3'd0);
      total_sum     = {1'b0, total_q} + 17'(cnt_d);
      total_d       = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  // Engine registers, including the registered outputs and display read.
  always_ff @(posedge clk_40M) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      i_q           <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      cnt_q         <= '0;
      collide_q     <= 1'b0;
      mask_q        <= '0;
      n_q           <= '0;
      hole_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_collide_q <= 1'b0;
      rsp_cleared_q <= '0;
      send_valid_q  <= 1'b0;
      send_n_q      <= '0;
      top_out_q     <= 1'b0;
      total_q       <= '0;
      disp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      i_q           <= i_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      collide_q     <= collide_d;
      mask_q        <= mask_d;
      n_q           <= n_d;
      hole_q        <= hole_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_collide_q <= rsp_collide_d;
      rsp_cleared_q <= rsp_cleared_d;
      send_valid_q  <= send_valid_d;
      send_n_q      <= send_n_d;
      top_out_q     <= top_out_d;
      total_q       <= total_d;
      disp_data_q   <= rdata_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_collide = rsp_collide_q;
  assign rsp_cleared = rsp_cleared_q;
  assign send_valid  = send_valid_q;
  assign send_n      = send_n_q;
  assign top_out     = top_out_q;
  assign total_lines = total_q;
  assign disp_data   = disp_data_q;

endmodule

// File: tb/tb_board_row_engine.sv
// Bench for board_row_engine: directed commands against a board-level model,
// a per-cycle compare process, and literal pins on key responses.
module tb_board_row_engine;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 4;
  localparam int RW = 5;

  logic           clk_40M = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [RW-1:0]  cmd_row;
  logic [4*W-1:0] cmd_mask;
  logic [2:0]     cmd_n;
  logic [CW-1:0]  cmd_hole;
  logic           rsp_valid, rsp_collide, send_valid, top_out;
  logic [2:0]     rsp_cleared, send_n;
  logic [15:0]    total_lines;
  logic [RW-1:0]  disp_row;
  logic [W-1:0]   disp_data;

  board_row_engine #(.W(W), .H(H), .CW(CW), .RW(RW)) dut (
    .clk_40M     (clk_40M),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_mask    (cmd_mask),
    .cmd_n       (cmd_n),
    .cmd_hole    (cmd_hole),
    .rsp_valid   (rsp_valid),
    .rsp_collide (rsp_collide),
    .rsp_cleared (rsp_cleared),
    .send_valid  (send_valid),
    .send_n      (send_n),
    .top_out     (top_out),
    .total_lines (total_lines),
    .disp_row    (disp_row),
    .disp_data   (disp_data)
  );

  always #12 clk_40M = ~clk_40M;

  int cyc = 0;
  always @(posedge clk_40M) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mb [H];
  bit m_busy  = 1'b0;
  bit m_abort = 1'b0;
  int m_c0, m_lat;
  bit m_collide;
  int m_cleared, m_send;
  bit m_top   = 1'b0;
  int m_total = 0;

  int last_rsp_cyc = -1;
  int last_collide, last_cleared, last_send, last_send_valid;

  function automatic int attack(input int c);
    if (c >= 4) return 4;
    if (c == 3) return 2;
    if (c == 2) return 1;
    return 0;
  endfunction

  function automatic logic [W-1:0] mrow(input logic [4*W-1:0] m, input int i);
    return m[W*i +: W];
  endfunction

  task automatic model_cmd(input int op, input int row, input logic [4*W-1:0] mask,
                           input int n, input int hole);
    logic [W-1:0] keep [$];
    logic [W-1:0] g;
    int nn;
    m_collide = 1'b0;
    m_cleared = 0;
    if (op == 1) begin
      for (int i = 0; i < 4; i++)
        if (row + i < H) mb[row+i] = mb[row+i] | mrow(mask, i);
      for (int r = H - 1; r >= 0; r--) begin
        if (mb[r] == {W{1'b1}}) m_cleared++;
        else keep.push_back(mb[r]);
      end
      for (int r = H - 1; r >= 0; r--)
        mb[r] = (H - 1 - r < keep.size()) ? keep[H-1-r] : '0;
      m_lat = 4 + H + m_cleared + 1;
    end else if (op == 2) begin
      nn = (n > 4) ? 4 : n;
      for (int r = 0; r < nn; r++) if (mb[r] != '0) m_top = 1'b1;
      g = '1;
      if (hole < W) g[hole] = 1'b0;
      for (int r = 0; r < H; r++) mb[r] = (r + nn < H) ? mb[r+nn] : g;
      m_lat = H + 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (row + i >= H) begin
          if (mrow(mask, i) != '0) m_collide = 1'b1;
        end else if ((mrow(mask, i) & mb[row+i]) != '0) begin
          m_collide = 1'b1;
        end
      end
      m_lat = 5;
    end
    m_send  = attack(m_cleared);
    m_total = (m_total + m_cleared > 65535) ? 65535 : m_total + m_cleared;
  endtask

  // ---------------- per-cycle compare ----------------
  bit rsp_due, busy_win;
  always @(negedge clk_40M) begin
    if (m_abort) begin
      chk("rsp_during_reset_abort", int'(rsp_valid), 0);
    end else if (!rst) begin
      rsp_due  = m_busy && (cyc == m_c0 + m_lat);
      busy_win = m_busy && (cyc > m_c0) && (cyc <= m_c0 + m_lat);
      chk("cmd_ready", int'(cmd_ready), int'(!busy_win));
      chk("rsp_valid", int'(rsp_valid), int'(rsp_due));
      if (rsp_due) begin
        chk("rsp_collide", int'(rsp_collide), int'(m_collide));
        chk("rsp_cleared", int'(rsp_cleared), (m_cleared > 7) ? 7 : m_cleared);
        chk("send_n", int'(send_n), m_send);
        chk("send_valid", int'(send_valid), int'(m_send != 0));
        chk("top_out_rsp", int'(top_out), int'(m_top));
        chk("total_lines_rsp", int'(total_lines), m_total);
        last_rsp_cyc    = cyc;
        last_collide    = int'(rsp_collide);
        last_cleared    = int'(rsp_cleared);
        last_send       = int'(send_n);
        last_send_valid = int'(send_valid);
      end else begin
        chk("send_valid_idle", int'(send_valid), 0);
        if (!m_busy) begin
          chk("top_out_idle", int'(top_out), int'(m_top));
          chk("total_lines_idle", int'(total_lines), m_total);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int op, input int row, input logic [4*W-1:0] mask,
                       input int n, input int hole);
    cmd_op    = 2'(op);
    cmd_row   = RW'(row);
    cmd_mask  = mask;
    cmd_n     = 3'(n);
    cmd_hole  = CW'(hole);
    cmd_valid = 1'b1;
  endtask

  task automatic wait_done();
    while (cyc <= m_c0 + m_lat) begin
      @(posedge clk_40M); #1;
    end
    m_busy = 1'b0;
  endtask

  task automatic issue(input int op, input int row, input logic [4*W-1:0] mask,
                       input int n, input int hole);
    @(posedge clk_40M); #1;
    drive(op, row, mask, n, hole);
    last_rsp_cyc = -1;
    m_c0 = cyc;
    model_cmd(op, row, mask, n, hole);
    m_busy = 1'b1;
    @(posedge clk_40M); #1;
    cmd_valid = 1'b0;
    wait_done();
  endtask

  task automatic read_board(input string tag);
    for (int r = 0; r < H; r++) begin
      @(posedge clk_40M); #1;
      disp_row = RW'(r);
      @(posedge clk_40M);
      @(negedge clk_40M);
      chk($sformatf("%s_row%0d", tag, r), int'(disp_data), int'(mb[r]));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_row   = '0;
    cmd_mask  = '0;
    cmd_n     = '0;
    cmd_hole  = '0;
    disp_row  = '0;
    for (int r = 0; r < H; r++) mb[r] = '0;
    repeat (3) @(posedge clk_40M);
    #1 rst = 1'b0;
    @(negedge clk_40M);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_total", int'(total_lines), 0);
    read_board("reset");

    // CHECK near the floor: rows 18,19 empty, mask row 2 would sit below row 19
    issue(0, 18, {10'h000, 10'h000, 10'h003, 10'h003}, 0, 0);
    chk("lit_chk_open_collide", last_collide, 0);
    chk("lit_chk_open_latency", last_rsp_cyc - m_c0, 5);
    issue(0, 18, {10'h000, 10'h001, 10'h003, 10'h003}, 0, 0);
    chk("lit_chk_floor_collide", last_collide, 1);
    // reserved opcode behaves as CHECK
    issue(3, 5, {10'h000, 10'h000, 10'h000, 10'h3FF}, 0, 0);
    chk("lit_rsvd_latency", last_rsp_cyc - m_c0, 5);

    // single-line clear
    issue(2, 0, '0, 1, 0);
    issue(1, 16, {10'h001, 10'h000, 10'h000, 10'h000}, 0, 0);
    chk("lit_single_cleared", last_cleared, 1);
    chk("lit_single_send_valid", last_send_valid, 0);
    chk("lit_single_latency", last_rsp_cyc - m_c0, 26);
    read_board("single");

    // tetris with a vertical I piece in column 0
    issue(2, 0, '0, 4, 0);
    issue(1, 16, {10'h001, 10'h001, 10'h001, 10'h001}, 0, 0);
    chk("lit_tetris_cleared", last_cleared, 4);
    chk("lit_tetris_send", last_send, 4);
    chk("lit_tetris_latency", last_rsp_cyc - m_c0, 29);
    read_board("tetris");

    // two non-adjacent rows cleared with a partial row between them
    issue(1, 16, {10'h155, 10'h3FE, 10'h155, 10'h3FE}, 0, 0);
    issue(1, 16, {10'h000, 10'h001, 10'h000, 10'h001}, 0, 0);
    chk("lit_double_cleared", last_cleared, 2);
    chk("lit_double_send", last_send, 1);
    read_board("double");

    // garbage pushes an occupied top row off the board
    issue(1, 0, {10'h000, 10'h000, 10'h010, 10'h000}, 0, 0);
    issue(2, 0, '0, 2, 3);
    @(negedge clk_40M);
    chk("lit_garbage_top_out", int'(top_out), 1);
    read_board("garbage");

    // clamped count with an out-of-range hole, then a zero-line garbage
    issue(2, 0, '0, 7, 15);
    issue(2, 0, '0, 0, 0);
    read_board("garb_clamp");

    // command held while busy: second one accepted only after the first completes
    @(posedge clk_40M); #1;
    drive(1, 0, {10'h000, 10'h000, 10'h000, 10'h001}, 0, 0);
    last_rsp_cyc = -1;
    m_c0 = cyc;
    model_cmd(1, 0, {10'h000, 10'h000, 10'h000, 10'h001}, 0, 0);
    m_busy = 1'b1;
    @(posedge clk_40M); #1;
    drive(0, 14, {10'h000, 10'h000, 10'h000, 10'h3FF}, 0, 0);
    wait_done();
    chk("lit_held_first_cleared", last_cleared, 4);
    m_c0 = cyc;
    model_cmd(0, 14, {10'h000, 10'h000, 10'h000, 10'h3FF}, 0, 0);
    m_busy = 1'b1;
    @(posedge clk_40M); #1;
    cmd_valid = 1'b0;
    wait_done();
    chk("lit_held_second_latency", last_rsp_cyc - m_c0, 5);
    read_board("held");

    // reset in the middle of SCAN aborts the LOCK
    issue(1, 0, {10'h000, 10'h000, 10'h000, 10'h0F0}, 0, 0);
    @(posedge clk_40M); #1;
    drive(1, 10, {10'h000, 10'h000, 10'h000, 10'h3FF}, 0, 0);
    m_c0 = cyc;
    m_lat = 4 + H + 1 + 1;
    m_busy = 1'b1;
    @(posedge clk_40M); #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk_40M);
    #1;
    rst     = 1'b1;
    m_abort = 1'b1;
    m_busy  = 1'b0;
    m_top   = 1'b0;
    m_total = 0;
    for (int r = 0; r < H; r++) mb[r] = '0;
    @(posedge clk_40M); #1;
    rst     = 1'b0;
    m_abort = 1'b0;
    repeat (30) @(posedge clk_40M);
    read_board("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(24 * 20000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
